pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the single-cycle structural adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Streaming valid/ready handshake on input and output with full backpressure.
- Used wherever wide adds must close timing at the board clock (datapath accumulators, address generators).

---
 rtl/pipelined_adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 18 +
 rtl/pipelined_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_adder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: operation modes
// and the stage-count helper.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One combinational adder slice: s = a + b + ci, carry out on co.
// Ports: a, b (W bits), ci in; s (W bits), co out.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] t;

  assign t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign {co, s} = t;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub split into CHUNK-bit slices, one per stage.
// Ports: clk, rst_n, in_valid/in_ready, a, b, sub; out_valid/out_ready, sum, ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int STAGES = ceil_div(WIDTH, CHUNK);
  localparam int L      = STAGES - 1;

  logic             stall;
  logic [WIDTH-1:0] bp;

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic             s_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];

  logic             v_nx [STAGES];
  logic             c_nx [STAGES];
  logic             s_nx [STAGES];
  logic [WIDTH-1:0] a_nx [STAGES];
  logic [WIDTH-1:0] b_nx [STAGES];
  logic [WIDTH-1:0] r_nx [STAGES];

  assign bp = (sub == MODE_ADD) ? b : ~b;

  assign out_valid = v_q[L];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int SW = (k == L) ? WIDTH - LO : CHUNK;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_new;
    logic             c_in;
    logic             s_in;
    logic             v_in;
    logic [SW-1:0]    s_sl;
    logic             c_sl;

    if (k == 0) begin : g_head
      // sub doubles as the +1 of the two's-complement negate
      assign a_in = a;
      assign b_in = bp;
      assign r_in = '0;
      assign c_in = sub;
      assign s_in = sub;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign r_in = r_q[k-1];
      assign c_in = c_q[k-1];
      assign s_in = s_q[k-1];
      assign v_in = v_q[k-1];
    end

    adder_slice #(
      .W (SW)
    ) u_slice (
      .a  (a_in[LO +: SW]),
      .b  (b_in[LO +: SW]),
      .ci (c_in),
      .s  (s_sl),
      .co (c_sl)
    );

    always_comb begin
      r_new = r_in;
      r_new[LO +: SW] = s_sl;
    end

    assign v_nx[k] = v_in;
    assign c_nx[k] = c_sl;
    assign s_nx[k] = s_in;
    assign a_nx[k] = a_in;
    assign b_nx[k] = b_in;
    assign r_nx[k] = r_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= 1'b0;
        s_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= v_nx[i];
        c_q[i] <= c_nx[i];
        s_q[i] <= s_nx[i];
        a_q[i] <= a_nx[i];
        b_q[i] <= b_nx[i];
        r_q[i] <= r_nx[i];
      end
    end
  end

  // for sub the top bit reports borrow, the inverse of the carry
  assign sum = {c_q[L] ^ (s_q[L] == MODE_SUB), r_q[L]};

  assign ovf = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1])
            && (r_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32/8 main instance plus
// 13/4 and 13/13 instances for narrow-slice and single-stage cases.
module tb_pipelined_adder;

  typedef struct {
    logic [32:0] s;
    logic        o;
    int          t;
    bit          l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] sum;
  logic        ovf;

  logic        v13 = 1'b0;
  logic [12:0] a13 = '0;
  logic [12:0] b13 = '0;
  logic        sub13 = 1'b0;
  logic        ordy13 = 1'b1;
  logic        irdy_a, irdy_b;
  logic        ov_a, ov_b;
  logic [13:0] sum_a, sum_b;
  logic        ovf_a, ovf_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  pipelined_adder #(.WIDTH(13), .CHUNK(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v13),
    .in_ready  (irdy_a),
    .a         (a13),
    .b         (b13),
    .sub       (sub13),
    .out_valid (ov_a),
    .out_ready (ordy13),
    .sum       (sum_a),
    .ovf       (ovf_a)
  );

  pipelined_adder #(.WIDTH(13), .CHUNK(13)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v13),
    .in_ready  (irdy_b),
    .a         (a13),
    .b         (b13),
    .sub       (sub13),
    .out_valid (ov_b),
    .out_ready (ordy13),
    .sum       (sum_b),
    .ovf       (ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got %0h want none", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("ovf", ovf, e.o);
        if (e.l) chk("latency", cyc - e.t, 4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic ts, input logic [32:0] es,
                      input logic eo, input bit push, input bit lat);
    int   n;
    exp_t e;
    n = 0;
    a = ta;
    b = tb;
    sub = ts;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      fail("send");
    end else if (push) begin
      e.s = es;
      e.o = eo;
      e.t = cyc;
      e.l = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sb.size() != 0) fail("drain");
  endtask

  initial begin
    int idx;
    int t0;
    int lat_a, lat_b;
    logic [13:0] ra, rb;

    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    send(32'd1000, 32'd1000, 1'b0, 33'd2000, 1'b0, 1, 1);
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 33'h1_0000_0000, 1'b0, 1, 0);
    send(32'd1000, 32'd3000, 1'b1, 33'h1_FFFF_F830, 1'b0, 1, 0);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 33'h0_8000_0000, 1'b1, 1, 0);
    drain();
    tick();
    chk("idle_after_drain", out_valid, 0);

    idx = 1;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (idx <= 6) begin
        a = 32'(idx);
        b = 32'(10 * idx);
        sub = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) chk("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_t e;
        e.s = 33'(11 * idx);
        e.o = 1'b0;
        e.t = cyc;
        e.l = 0;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", idx, 7);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'(100 + i), 32'd1, 1'b0, 33'd0, 1'b0, 0, 0);
    tick();
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (8) tick();
    chk("post_rst_idle", out_valid, 0);
    send(32'd5, 32'd7, 1'b0, 33'd12, 1'b0, 1, 1);
    drain();

    lat_a = -1;
    lat_b = -1;
    ra = '0;
    rb = '0;
    a13 = 13'h1FFF;
    b13 = 13'h1FFF;
    v13 = 1'b1;
    #1;
    t0 = cyc;
    tick();
    v13 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (lat_a < 0 && ov_a) begin
        lat_a = cyc - t0;
        ra = sum_a;
      end
      if (lat_b < 0 && ov_b) begin
        lat_b = cyc - t0;
        rb = sum_b;
      end
      tick();
    end
    chk("w13c4_sum", ra, 14'h3FFE);
    chk("w13c4_lat", lat_a, 4);
    chk("w13c13_sum", rb, 14'h3FFE);
    chk("w13c13_lat", lat_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
